// File: rtl/hood_pkg.sv
// ---------------------------------------------------------------------------
// hood_pkg
//   Shared definitions for the range-hood front panel and mode controller.
//   - Button indices into the 5-bit button vectors.
//   - One-hot mode encodings used by the mode state machine.
//   - Default system clock and the ms -> cycle conversion used for timers.
// ---------------------------------------------------------------------------
package hood_pkg;

  localparam int N_BTN      = 5;

  localparam int BTN_MENU   = 0;
  localparam int BTN_SMOKE1 = 1;
  localparam int BTN_SMOKE2 = 2;
  localparam int BTN_SMOKE3 = 3;
  localparam int BTN_CLEAN  = 4;

  localparam int DEF_CLK_HZ = 100_000_000;

  // One-hot mode encodings; STANDBY is the all-zero state.
  typedef enum logic [4:0] {
    STANDBY = 5'b00000,
    MENU    = 5'b00001,
    SMOKE1  = 5'b00010,
    SMOKE2  = 5'b00100,
    SMOKE3  = 5'b01000,
    CLEAN   = 5'b10000
  } hood_mode_e;

  // Divide first so that 100 MHz * 3000 ms stays inside 32 bits.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/hood_btn_debounce.sv
// ---------------------------------------------------------------------------
// hood_btn_debounce
//   One button channel: 2-flop synchroniser, stability counter and the
//   debounced level register. Press and release are filtered identically.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     raw        in   raw (asynchronous, bouncing) button input
//     level      out  registered debounced level
//     level_nxt  out  value level will take on the next edge; lets the
//                     parent register a press pulse in step with level
// ---------------------------------------------------------------------------
module hood_btn_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic level_nxt
);

  localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             s;

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], raw};
    cnt_d   = '0;
    level_d = level_q;
    // The counter only advances while the synchronised input disagrees
    // with the accepted level; any agreement (a bounce back) restarts it.
    // The DEB_CYC-th consecutive disagreement commits the new level.
    if (s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/hood_button_conditioner.sv
// ---------------------------------------------------------------------------
// hood_button_conditioner
//   Front end for the range-hood mode controller. Debounces the five panel
//   buttons and turns accepted presses into single-cycle pulses, at most one
//   per clock, plus a separate menu long-press event.
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   asynchronous active-low reset
//     btn_raw     in   [4:0] raw buttons: 0 menu, 1 smoke1, 2 smoke2,
//                      3 smoke3, 4 clean (active high)
//     btn_level   out  [4:0] debounced levels (1 = held)
//     btn_pulse   out  [4:0] one-hot or zero press pulse, one cycle
//     menu_long   out  one-cycle pulse after menu held LONG_CYC cycles
//     press_drop  out  one-cycle flag: a simultaneous press was discarded
//
//   All outputs are registered; there is no combinational path from btn_raw.
// ---------------------------------------------------------------------------
module hood_button_conditioner
  import hood_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             menu_long,
  output logic             press_drop
);

  localparam int DEB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_PRESS_MS);
  localparam int LONG_W   = (LONG_CYC < 2) ? 1 : $clog2(LONG_CYC + 1);

  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYC);

  logic [N_BTN-1:0]  level, level_nxt, rise;
  logic [N_BTN-1:0]  btn_pulse_q, btn_pulse_d;
  logic              press_drop_q, press_drop_d;
  logic              menu_long_q, menu_long_d;
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;

  // -------------------------------------------------------------------------
  // Per-button synchroniser + debouncer
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    hood_btn_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .raw       (btn_raw[g]),
      .level     (level[g]),
      .level_nxt (level_nxt[g])
    );
  end

  // Rising edge of the level that will be registered this cycle, so the
  // pulse lands on the same edge as btn_level.
  assign rise = level_nxt & ~level;

  // -------------------------------------------------------------------------
  // Priority arbiter: menu > clean > smoke3 > smoke2 > smoke1.
  // Losers are dropped outright; the mode FSM only ever sees one press.
  // -------------------------------------------------------------------------
  always_comb begin
    btn_pulse_d = '0;
    if (rise[BTN_MENU]) begin
      btn_pulse_d[BTN_MENU] = 1'b1;
    end else if (rise[BTN_CLEAN]) begin
      btn_pulse_d[BTN_CLEAN] = 1'b1;
    end else if (rise[BTN_SMOKE3]) begin
      btn_pulse_d[BTN_SMOKE3] = 1'b1;
    end else if (rise[BTN_SMOKE2]) begin
      btn_pulse_d[BTN_SMOKE2] = 1'b1;
    end else if (rise[BTN_SMOKE1]) begin
      btn_pulse_d[BTN_SMOKE1] = 1'b1;
    end
    // More than one bit set <=> clearing the lowest set bit leaves something.
    press_drop_d = |(rise & (rise - N_BTN'(1)));
  end

  // -------------------------------------------------------------------------
  // Menu long-press
  //   The counter tracks cycles since the debounced menu level went high.
  //   The event is registered, so it is raised while the counter sits at
  //   LONG_CYC-1 and appears LONG_CYC edges after the level rise. The counter
  //   then parks one step past that value, which keeps the compare false
  //   until a release clears it.
  // -------------------------------------------------------------------------
  always_comb begin
    long_cnt_d  = '0;
    menu_long_d = 1'b0;
    if (level[BTN_MENU]) begin
      long_cnt_d  = (long_cnt_q == LONG_SAT) ? long_cnt_q : long_cnt_q + LONG_W'(1);
      menu_long_d = (long_cnt_q == LONG_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_pulse_q  <= '0;
      press_drop_q <= 1'b0;
      menu_long_q  <= 1'b0;
      long_cnt_q   <= '0;
    end else begin
      btn_pulse_q  <= btn_pulse_d;
      press_drop_q <= press_drop_d;
      menu_long_q  <= menu_long_d;
      long_cnt_q   <= long_cnt_d;
    end
  end

  assign btn_level  = level;
  assign btn_pulse  = btn_pulse_q;
  assign menu_long  = menu_long_q;
  assign press_drop = press_drop_q;

endmodule

// File: tb/tb_hood_button_conditioner.sv
module tb_hood_button_conditioner;

  localparam int CLK_HZ  = 1000;
  localparam int DEB     = CLK_HZ / 1000 * 20;    // 20
  localparam int LONG    = CLK_HZ / 1000 * 3000;  // 3000
  localparam int RISE_AT = 1 + DEB + 1;           // raw sampled at edge 1 -> level at edge k+21

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level, btn_pulse;
  logic       menu_long, press_drop;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hood_button_conditioner #(
    .CLK_HZ        (CLK_HZ),
    .DEBOUNCE_MS   (20),
    .LONG_PRESS_MS (3000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .menu_long  (menu_long),
    .press_drop (press_drop)
  );

  // -------------------------------------------------------------------------
  // Reference model: a button's level flips once the value seen two edges
  // after sampling has disagreed with the level for DEB consecutive edges.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]      h0, h1;   // raw as sampled 1 and 2 edges ago
    logic [4:0]      lvl;
    logic [4:0]      pulse;
    logic            lng;
    logic            drop;
    int              hold;     // edges the menu level has been high
    logic [4:0][7:0] run;      // consecutive disagreeing edges per button
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t mstep(input mstate_t c, input logic [4:0] raw);
    mstate_t n;
    logic [4:0] s, nl, rs;
    int r;
    int ord [5];
    ord = '{0, 4, 3, 2, 1};
    n = c;
    s = c.h1;
    nl = c.lvl;
    for (int i = 0; i < 5; i++) begin
      r = (s[i] != c.lvl[i]) ? int'(c.run[i]) + 1 : 0;
      if (r == DEB) begin
        nl[i] = s[i];
        r = 0;
      end
      n.run[i] = 8'(r);
    end
    rs = nl & ~c.lvl;
    n.pulse = '0;
    for (int k = 4; k >= 0; k--) begin
      if (rs[ord[k]]) n.pulse = 5'(1 << ord[k]);
    end
    n.drop = ($countones(rs) > 1);
    n.hold = c.lvl[0] ? c.hold + 1 : 0;
    n.lng  = c.lvl[0] && (c.hold + 1 == LONG);
    n.lvl  = nl;
    n.h1   = c.h0;
    n.h0   = raw;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= mstep(m, btn_raw);
  end

  // -------------------------------------------------------------------------
  task automatic test_reset();
    btn_raw = 5'b10101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== 12'h000) begin
        nerr++;
        $display("FAIL reset_state c=%0d got lvl=%b pls=%b long=%b drop=%b want all 0",
                 c, btn_level, btn_pulse, menu_long, press_drop);
      end
    end
    btn_raw = '0;
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
        nerr++;
        $display("FAIL reset_idle c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, btn_level, btn_pulse,
                 menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
      end
    end
  endtask

  task automatic test_clean_press();
    int rise_at = -1, fall_at = -1, npulse = 0;
    btn_raw = 5'b00010;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
        nerr++;
        $display("FAIL press_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, btn_level, btn_pulse,
                 menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
      end
      if (btn_pulse != 0) npulse++;
      if (btn_level[1] && rise_at < 0) begin
        rise_at = c;
        nvec++;
        if (btn_pulse !== 5'b00010) begin
          nerr++;
          $display("FAIL press_pulse got %b want 00010", btn_pulse);
        end
      end
    end
    btn_raw = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
        nerr++;
        $display("FAIL release_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, btn_level, btn_pulse,
                 menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
      end
      if (btn_pulse != 0) npulse++;
      if (!btn_level[1] && fall_at < 0) fall_at = c;
    end
    nvec++;
    if (rise_at != RISE_AT) begin
      nerr++;
      $display("FAIL press_latency got %0d want %0d", rise_at, RISE_AT);
    end
    nvec++;
    if (fall_at != RISE_AT) begin
      nerr++;
      $display("FAIL release_latency got %0d want %0d", fall_at, RISE_AT);
    end
    nvec++;
    if (npulse != 1) begin
      nerr++;
      $display("FAIL press_pulse_count got %0d want 1", npulse);
    end
  endtask

  task automatic test_bounce();
    int rise_at = -1, npulse = 0;
    for (int c = 0; c < 50; c++) begin
      if (c % 5 == 0) btn_raw[2] = ((c / 5) % 2 == 0);
      @(negedge clk);
      nvec++;
      if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000) begin
        nerr++;
        $display("FAIL bounce_quiet c=%0d got lvl=%b pls=%b want 0/0", c, btn_level, btn_pulse);
      end
    end
    btn_raw[2] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
        nerr++;
        $display("FAIL bounce_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, btn_level, btn_pulse,
                 menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
      end
      if (btn_pulse != 0) npulse++;
      if (btn_pulse === 5'b00100 && rise_at < 0) rise_at = c;
    end
    nvec++;
    if (npulse != 1 || rise_at != RISE_AT) begin
      nerr++;
      $display("FAIL bounce_pulse got count=%0d at=%0d want count=1 at=%0d", npulse, rise_at, RISE_AT);
    end
    btn_raw = '0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    btn_raw = 5'b11000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
        nerr++;
        $display("FAIL simul_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, btn_level, btn_pulse,
                 menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
      end
      if (c == RISE_AT) begin
        nvec++;
        if (btn_pulse !== 5'b10000 || press_drop !== 1'b1 || btn_level !== 5'b11000) begin
          nerr++;
          $display("FAIL simul_arb got pls=%b drop=%b lvl=%b want 10000/1/11000",
                   btn_pulse, press_drop, btn_level);
        end
      end
    end
    btn_raw = '0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_long_press();
    for (int rep = 0; rep < 2; rep++) begin
      int nlong = 0, long_at = -1, menu_at = -1;
      btn_raw[0] = 1'b1;
      for (int c = 1; c <= 3100; c++) begin
        @(negedge clk);
        nvec++;
        if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
          nerr++;
          $display("FAIL long_model r=%0d c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", rep, c, btn_level,
                   btn_pulse, menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
        end
        if (menu_long) begin
          nlong++;
          if (long_at < 0) long_at = c;
        end
        if (btn_pulse === 5'b00001 && menu_at < 0) menu_at = c;
      end
      btn_raw[0] = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (menu_long) nlong++;
      end
      nvec++;
      if (menu_at != RISE_AT || long_at != RISE_AT + LONG || nlong != 1) begin
        nerr++;
        $display("FAIL long_press r=%0d got menu_at=%0d long_at=%0d n=%0d want %0d/%0d/1",
                 rep, menu_at, long_at, nlong, RISE_AT, RISE_AT + LONG);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rise_at = -1, npulse = 0;
    btn_raw[0] = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++;
    if ({btn_level, btn_pulse, menu_long, press_drop} !== 12'h000) begin
      nerr++;
      $display("FAIL rst_mid_immediate got %b/%b/%b/%b want 0", btn_level, btn_pulse, menu_long, press_drop);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
        nerr++;
        $display("FAIL rst_mid_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, btn_level, btn_pulse,
                 menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
      end
      if (btn_pulse != 0) npulse++;
      if (btn_pulse === 5'b00001 && rise_at < 0) rise_at = c;
    end
    nvec++;
    if (npulse != 1 || rise_at != RISE_AT) begin
      nerr++;
      $display("FAIL rst_mid_pulse got n=%0d at=%0d want 1/%0d", npulse, rise_at, RISE_AT);
    end
    // Reset while the level is high must clear it at once.
    rst = 1'b0;
    #1;
    nvec++;
    if (btn_level !== 5'b00000) begin
      nerr++;
      $display("FAIL rst_level_high got %b want 00000", btn_level);
    end
    btn_raw = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_glitch();
    btn_raw[4] = 1'b1;
    for (int c = 0; c < 55; c++) begin
      if (c == 15) btn_raw[4] = 1'b0;
      @(negedge clk);
      nvec++;
      if (btn_level !== 5'b0 || btn_pulse !== 5'b0 || press_drop !== 1'b0) begin
        nerr++;
        $display("FAIL glitch c=%0d got lvl=%b pls=%b drop=%b want 0/0/0", c, btn_level, btn_pulse, press_drop);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) btn_raw = btn_raw ^ 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 199) == 0) btn_raw = 5'($urandom);
      @(negedge clk);
      nvec++;
      if ({btn_level, btn_pulse, menu_long, press_drop} !== {m.lvl, m.pulse, m.lng, m.drop}) begin
        nerr++;
        $display("FAIL random c=%0d raw=%b got %b/%b/%b/%b want %b/%b/%b/%b", c, btn_raw, btn_level,
                 btn_pulse, menu_long, press_drop, m.lvl, m.pulse, m.lng, m.drop);
      end
    end
    btn_raw = '0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_long_press();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
